// File: rtl/universal_shift_reg_n.sv
// -----------------------------------------------------------------------------
// universal_shift_reg_n
//
// Purpose:
//   WIDTH-bit universal shift register. It can hold, shift right or left with
//   serial inputs, parallel-load, arithmetic-shift right and, optionally,
//   rotate. Two ways of operating:
//     * Streaming: in IDLE with i_en=1, the selected operation is applied once
//       on every clock edge.
//     * Multi-step: a pulse on i_start latches the mode and a step count, then
//       applies that many steps on enabled edges. o_busy and o_done report
//       progress.
//   This block is the serial and parallel front end for serialisers,
//   bit-stream alignment and datapath scaling.
//
// Optional feature:
//   Define the macro USR_ROTATE_EN to enable ROR (mode 101) and ROL (mode 110).
//   When the macro is not defined, those two codes act as hold.
//
// Parameters:
//   WIDTH   register width, must be >= 2
//   AMTW    width of i_amt. It is derived from WIDTH; leave it at its default.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous reset, active-low
//   i_en       streaming enable in IDLE; stalls the engine when low in RUN
//   i_mode     operation select
//                000 hold   001 SHR   010 SHL   011 load
//                100 ASR    101 ROR   110 ROL   111 hold
//   i_start    launches a multi-step operation; mode and amount are latched
//   i_amt      step count for i_start. Values above WIDTH saturate to WIDTH.
//   i_si_msb   serial input entering at the MSB on shift right
//   i_si_lsb   serial input entering at the LSB on shift left
//   i_xp       parallel load data
//   o_qp       register contents
//   o_so_lsb   o_qp[0], combinational
//   o_so_msb   o_qp[WIDTH-1], combinational
//   o_busy     a multi-step operation still has steps pending
//   o_done     one-cycle pulse when a multi-step operation completes
// -----------------------------------------------------------------------------
module universal_shift_reg_n #(
  parameter int WIDTH = 8,
  parameter int AMTW  = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [2:0]       i_mode,
  input  logic             i_start,
  input  logic [AMTW-1:0]  i_amt,
  input  logic             i_si_msb,
  input  logic             i_si_lsb,
  input  logic [WIDTH-1:0] i_xp,
  output logic [WIDTH-1:0] o_qp,
  output logic             o_so_lsb,
  output logic             o_so_msb,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ASR  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ROL  = 3'b110;

  localparam logic [AMTW-1:0] AMT_MAX = AMTW'(WIDTH);
  localparam logic [AMTW-1:0] AMT_ONE = AMTW'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [2:0]       r_mode;
  logic [AMTW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_qp;
  logic             r_busy;
  logic             r_done;

  logic [AMTW-1:0]  w_amtSat;
  logic [WIDTH-1:0] w_stepLive;
  logic [WIDTH-1:0] w_stepRun;

  // Computes the value one operation produces. Streaming and multi-step use
  // this same function, so every mode decodes identically on both paths.
  // Mode 111 and any disabled rotate code fall through to hold.
  function automatic logic [WIDTH-1:0] f_step(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] q,
    input logic             sm,
    input logic             sl,
    input logic [WIDTH-1:0] x
  );
    logic [WIDTH-1:0] v;
    v = q;
    case (m)
      MODE_SHR:  v = {sm, q[WIDTH-1:1]};
      MODE_SHL:  v = {q[WIDTH-2:0], sl};
      MODE_LOAD: v = x;
      MODE_ASR:  v = {q[WIDTH-1], q[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
      MODE_ROR:  v = {q[0], q[WIDTH-1:1]};
      MODE_ROL:  v = {q[WIDTH-2:0], q[WIDTH-1]};
`else
      MODE_ROR:  v = q;
      MODE_ROL:  v = q;
`endif
      MODE_HOLD: v = q;
      default:   v = q;
    endcase
    return v;
  endfunction

  // Requests larger than the register width are clamped to WIDTH steps.
  // The step function is evaluated twice: once with the live mode for
  // streaming and for the first step at launch, and once with the latched
  // mode for the RUN steps. The serial inputs are sampled live on every step.
  always_comb begin
    w_amtSat   = (i_amt > AMT_MAX) ? AMT_MAX : i_amt;
    w_stepLive = f_step(i_mode, r_qp, i_si_msb, i_si_lsb, i_xp);
    w_stepRun  = f_step(r_mode, r_qp, i_si_msb, i_si_lsb, i_xp);
  end

  // Control FSM and datapath register.
  // The first step happens on the launch edge itself. r_cnt therefore holds
  // the number of steps still to do after that edge, and the engine only
  // enters RUN when at least one step remains. A reset during RUN clears all
  // state, so no done pulse is produced.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_HOLD;
      r_cnt   <= '0;
      r_qp    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (w_amtSat == '0) begin
              r_done <= 1'b1;
            end else if (i_mode == MODE_LOAD) begin
              r_qp   <= i_xp;
              r_done <= 1'b1;
            end else begin
              r_qp   <= w_stepLive;
              r_mode <= i_mode;
              if (w_amtSat == AMT_ONE) begin
                r_done <= 1'b1;
              end else begin
                r_cnt   <= w_amtSat - AMT_ONE;
                r_busy  <= 1'b1;
                r_state <= ST_RUN;
              end
            end
          end else if (i_en) begin
            r_qp <= w_stepLive;
          end
        end
        ST_RUN: begin
          if (i_en) begin
            r_qp  <= w_stepRun;
            r_cnt <= r_cnt - AMT_ONE;
            if (r_cnt == AMT_ONE) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The serial outputs tap the register directly, so they follow o_qp with no
  // extra cycle of delay.
  always_comb begin
    o_qp     = r_qp;
    o_so_lsb = r_qp[0];
    o_so_msb = r_qp[WIDTH-1];
    o_busy   = r_busy;
    o_done   = r_done;
  end

endmodule

// File: tb/tb_universal_shift_reg_n.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_reg_n
//
// Purpose:
//   Self-checking bench for universal_shift_reg_n with WIDTH=8. The bench keeps
//   a behavioural model written in integer arithmetic: a value, a count of
//   remaining steps and the latched mode. On every falling edge, outside
//   reset, the DUT outputs are compared against that model. Directed vectors
//   with hand-computed literal values also pin down the model itself.
//
// Optional feature:
//   Define USR_ROTATE_EN in both the bench and the RTL build so the expected
//   rotate results match.
// -----------------------------------------------------------------------------
module tb_universal_shift_reg_n;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [2:0]    mode;
  logic          start;
  logic [AW-1:0] amt;
  logic          siMsb;
  logic          siLsb;
  logic [W-1:0]  xp;
  logic [W-1:0]  qp;
  logic          soLsb;
  logic          soMsb;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  // Model state
  int mQ    = 0;
  int mRem  = 0;
  int mMode = 0;
  int mDone = 0;

  universal_shift_reg_n #(.WIDTH(W)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_en     (en),
    .i_mode   (mode),
    .i_start  (start),
    .i_amt    (amt),
    .i_si_msb (siMsb),
    .i_si_lsb (siLsb),
    .i_xp     (xp),
    .o_qp     (qp),
    .o_so_lsb (soLsb),
    .o_so_msb (soMsb),
    .o_busy   (busy),
    .o_done   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Computes the result of one operation with plain integer arithmetic.
  function automatic int stepVal(input int md, input int q, input logic sm,
                                 input logic sl, input int x);
    int msbw;
    int mask;
    msbw = 1 << (W - 1);
    mask = (1 << W) - 1;
    case (md)
      1: return (q >> 1) | (sm ? msbw : 0);
      2: return ((q << 1) & mask) | (sl ? 1 : 0);
      3: return x & mask;
      4: return (q >> 1) | (q & msbw);
`ifdef USR_ROTATE_EN
      5: return (q >> 1) | (((q & 1) != 0) ? msbw : 0);
      6: return ((q << 1) & mask) | (((q & msbw) != 0) ? 1 : 0);
`endif
      default: return q;
    endcase
  endfunction

  // Computes the model's next state from the current model state and the
  // inputs presented at this edge.
  function automatic void modelNext(output int nQ, output int nRem,
                                    output int nMode, output int nDone);
    int n;
    nQ    = mQ;
    nRem  = mRem;
    nMode = mMode;
    nDone = 0;
    if (mRem > 0) begin
      if (en) begin
        nQ   = stepVal(mMode, mQ, siMsb, siLsb, int'(xp));
        nRem = mRem - 1;
        if (nRem == 0) nDone = 1;
      end
    end else if (start) begin
      n = (int'(amt) > W) ? W : int'(amt);
      if (n == 0) begin
        nDone = 1;
      end else if (mode == 3'b011) begin
        nQ    = int'(xp);
        nDone = 1;
      end else begin
        nQ    = stepVal(int'(mode), mQ, siMsb, siLsb, int'(xp));
        nRem  = n - 1;
        nMode = int'(mode);
        if (nRem == 0) nDone = 1;
      end
    end else if (en) begin
      nQ = stepVal(int'(mode), mQ, siMsb, siLsb, int'(xp));
    end
  endfunction

  // Advances the model on each clock edge; reset clears it asynchronously.
  always @(posedge clk or negedge rst_n) begin
    int nQ, nRem, nMode, nDone;
    if (!rst_n) begin
      mQ    <= 0;
      mRem  <= 0;
      mMode <= 0;
      mDone <= 0;
    end else begin
      modelNext(nQ, nRem, nMode, nDone);
      mQ    <= nQ;
      mRem  <= nRem;
      mMode <= nMode;
      mDone <= nDone;
    end
  end

  // Compares one value and records the outcome.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Compares every DUT output against the model on each falling edge while
  // reset is released.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checkOutput("cmp_qp",    32'(qp),    32'(mQ));
      checkOutput("cmp_busy",  32'(busy),  32'(mRem > 0));
      checkOutput("cmp_done",  32'(done),  32'(mDone));
      checkOutput("cmp_solsb", 32'(soLsb), 32'(mQ & 1));
      checkOutput("cmp_somsb", 32'(soMsb), 32'((mQ >> (W - 1)) & 1));
    end
  end

  // Sets all inputs at once.
  task automatic applyStimulus(input logic e, input logic [2:0] m,
                               input logic s, input logic [AW-1:0] a,
                               input logic sm, input logic sl,
                               input logic [W-1:0] x);
    en    = e;
    mode  = m;
    start = s;
    amt   = a;
    siMsb = sm;
    siLsb = sl;
    xp    = x;
  endtask

  // Lets one clock edge go by, then waits so outputs have settled.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic loadValue(input logic [W-1:0] v);
    applyStimulus(1'b1, 3'b011, 1'b0, 4'd0, 1'b0, 1'b0, v);
    tick();
  endtask

  initial begin
    int cycles;
    applyStimulus(1'b0, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_qp",   32'(qp),   32'h00);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reset in the middle of a stream clears the outputs without a clock edge.
    loadValue(8'h3C);
    applyStimulus(1'b1, 3'b001, 1'b0, 4'd0, 1'b1, 1'b0, 8'h00);
    tick();
    checkOutput("stream_pre_reset", 32'(qp), 32'h9E);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_qp",   32'(qp),   32'h00);
    checkOutput("async_reset_busy", 32'(busy), 32'h0);
    checkOutput("async_reset_done", 32'(done), 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Parallel load, then a shift right with 1 entering at the MSB.
    loadValue(8'hA5);
    checkOutput("load_A5",     32'(qp),    32'hA5);
    checkOutput("so_lsb_pre",  32'(soLsb), 32'h1);
    applyStimulus(1'b1, 3'b001, 1'b0, 4'd0, 1'b1, 1'b0, 8'h00);
    tick();
    checkOutput("shr_D2", 32'(qp), 32'hD2);

    // With en=0 in IDLE the register holds.
    applyStimulus(1'b0, 3'b001, 1'b0, 4'd0, 1'b1, 1'b0, 8'h00);
    tick();
    checkOutput("en0_hold", 32'(qp), 32'hD2);

    // Multi-step SHL by 3 on A5 with 0 entering at the LSB.
    loadValue(8'hA5);
    applyStimulus(1'b1, 3'b010, 1'b1, 4'd3, 1'b0, 1'b0, 8'h00);
    tick();
    checkOutput("shl3_e0_qp",   32'(qp),   32'h4A);
    checkOutput("shl3_e0_busy", 32'(busy), 32'h1);
    applyStimulus(1'b1, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00);
    tick();
    checkOutput("shl3_e1_busy", 32'(busy), 32'h1);
    tick();
    checkOutput("shl3_qp",   32'(qp),   32'h28);
    checkOutput("shl3_done", 32'(done), 32'h1);
    checkOutput("shl3_busy", 32'(busy), 32'h0);
    tick();
    checkOutput("shl3_done_pulse", 32'(done), 32'h0);

    // ASR by 2 on 90. While done is high, a start with amt=0 is issued.
    loadValue(8'h90);
    applyStimulus(1'b1, 3'b100, 1'b1, 4'd2, 1'b0, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b1, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00);
    tick();
    checkOutput("asr2_qp",   32'(qp),   32'hE4);
    checkOutput("asr2_done", 32'(done), 32'h1);
    applyStimulus(1'b1, 3'b001, 1'b1, 4'd0, 1'b1, 1'b1, 8'h00);
    tick();
    checkOutput("amt0_qp",   32'(qp),   32'hE4);
    checkOutput("amt0_done", 32'(done), 32'h1);
    checkOutput("amt0_busy", 32'(busy), 32'h0);

    // A single step completes on the launch edge and busy never rises.
    applyStimulus(1'b1, 3'b001, 1'b1, 4'd1, 1'b0, 1'b0, 8'h00);
    tick();
    checkOutput("amt1_qp",   32'(qp),   32'h72);
    checkOutput("amt1_done", 32'(done), 32'h1);
    checkOutput("amt1_busy", 32'(busy), 32'h0);

    // A start in load mode performs one load and finishes immediately.
    applyStimulus(1'b1, 3'b011, 1'b1, 4'd4, 1'b0, 1'b0, 8'h3C);
    tick();
    checkOutput("start_load_qp",   32'(qp),   32'h3C);
    checkOutput("start_load_done", 32'(done), 32'h1);
    checkOutput("start_load_busy", 32'(busy), 32'h0);

    // amt=15 is clamped to 8 steps. Shifting in ones from 00 gives FF.
    loadValue(8'h00);
    applyStimulus(1'b1, 3'b010, 1'b1, 4'd15, 1'b0, 1'b1, 8'h00);
    tick();
    applyStimulus(1'b1, 3'b000, 1'b0, 4'd0, 1'b0, 1'b1, 8'h00);
    cycles = 1;
    while (done !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    checkOutput("sat_cycles", 32'(cycles), 32'd8);
    checkOutput("sat_qp",     32'(qp),     32'hFF);

    // Rotate, streaming and multi-step.
    loadValue(8'h81);
    applyStimulus(1'b1, 3'b101, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00);
    tick();
`ifdef USR_ROTATE_EN
    checkOutput("ror_81", 32'(qp), 32'hC0);
`else
    checkOutput("ror_81", 32'(qp), 32'h81);
`endif
    loadValue(8'h81);
    applyStimulus(1'b1, 3'b110, 1'b1, 4'd3, 1'b0, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b1, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    checkOutput("rol3_done", 32'(done), 32'h1);
`ifdef USR_ROTATE_EN
    checkOutput("rol3_qp", 32'(qp), 32'h0C);
`else
    checkOutput("rol3_qp", 32'(qp), 32'h81);
`endif

    // SHL by 5 stalled after step 2, then aborted by reset.
    loadValue(8'h0F);
    applyStimulus(1'b1, 3'b010, 1'b1, 4'd5, 1'b0, 1'b1, 8'h00);
    tick();
    applyStimulus(1'b1, 3'b000, 1'b0, 4'd0, 1'b0, 1'b1, 8'h00);
    tick();
    checkOutput("stall_step2_qp", 32'(qp), 32'h3F);
    applyStimulus(1'b0, 3'b011, 1'b1, 4'd1, 1'b0, 1'b1, 8'hAA);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("stall_qp",   32'(qp),   32'h3F);
    checkOutput("stall_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_qp",   32'(qp),   32'h00);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_done", 32'(done), 32'h0);
    applyStimulus(1'b0, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    checkOutput("abort_no_done", 32'(done), 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
